// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake, iterative one-bit-per-cycle shifter,
// carry/negative/zero flags and a sticky halt flag set by the stp opcode.
module alu_seq #(
  parameter int W       = 8,
  parameter int SHAMT_W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [2:0]   OP,
  input  logic [W-1:0] input_a,
  input  logic [W-1:0] input_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic         zero,
  output logic         carry,
  output logic         neg,
  output logic         halted
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t                      state, state_nxt;
  logic        [W-1:0]         work;
  logic        [SHAMT_W-1:0]   cnt;
  logic                        dir_right;
  logic signed [SHAMT_W-1:0]   amt;
  logic        [SHAMT_W-1:0]   amt_mag;
  logic        [W:0]           sum;
  logic        [W:0]           step;
  logic                        accept;
  logic                        load_shift;
  logic                        done_nxt;
  logic                        halt_nxt;
  logic        [W-1:0]         res_nxt;
  logic                        cy_nxt;

  // One shift position with zero fill; MSB of the result is the bit pushed out.
  function automatic logic [W:0] shift_step(input logic [W-1:0] w, input logic right);
    if (right) shift_step = {w[0], 1'b0, w[W-1:1]};
    else       shift_step = {w[W-1], w[W-2:0], 1'b0};
  endfunction

  assign amt     = signed'(input_b[SHAMT_W-1:0]);
  // Two's-complement magnitude; the most-negative amount maps to 2^(SHAMT_W-1) unsigned.
  assign amt_mag = amt[SHAMT_W-1] ? (~input_b[SHAMT_W-1:0] + CNT_ONE) : input_b[SHAMT_W-1:0];
  assign sum     = {1'b0, input_a} + {1'b0, input_b};
  assign step    = shift_step(work, dir_right);
  assign accept  = start && (state == IDLE) && !halted;
  assign busy    = (state == SHIFT);

  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    halt_nxt   = halted;
    res_nxt    = out;
    cy_nxt     = carry;
    load_shift = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          done_nxt = 1'b1;
          cy_nxt   = 1'b0;
          casez (OP)
            3'b000: begin
              res_nxt  = '0;
              halt_nxt = 1'b1;
            end
            3'b001: begin
              if (amt_mag == '0) begin
                res_nxt = input_a;
              end else begin
                done_nxt   = 1'b0;
                cy_nxt     = carry;
                load_shift = 1'b1;
                state_nxt  = SHIFT;
              end
            end
            3'b010: res_nxt = input_a[W-1] ? '0 : W'(1);
            3'b011: res_nxt = ~(input_a | input_b);
            3'b10?: {cy_nxt, res_nxt} = sum;
            default: res_nxt = input_b;
          endcase
        end
      end
      SHIFT: begin
        if (cnt == CNT_ONE) begin
          res_nxt   = step[W-1:0];
          cy_nxt    = step[W];
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architectural outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      halted <= 1'b0;
      out    <= '0;
      zero   <= 1'b1;
      carry  <= 1'b0;
      neg    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= done_nxt;
      halted <= halt_nxt;
      if (done_nxt) begin
        out   <= res_nxt;
        zero  <= (res_nxt == '0);
        carry <= cy_nxt;
        neg   <= res_nxt[W-1];
      end
    end
  end

  // Shift working registers; only meaningful while state is SHIFT
  always_ff @(posedge Clk) begin
    if (load_shift) begin
      work      <= input_a;
      cnt       <= amt_mag;
      dir_right <= amt[SHAMT_W-1];
    end else if (state == SHIFT) begin
      work <= step[W-1:0];
      cnt  <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected results, monitor pops on done.
module tb_alu_seq;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [2:0]   OP;
  logic [W-1:0] input_a, input_b;
  logic         busy, done, zero, carry, neg, halted;
  logic [W-1:0] out;

  alu_seq #(.W(W), .SHAMT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .OP(OP),
    .input_a(input_a), .input_b(input_b),
    .busy(busy), .done(done), .out(out), .zero(zero),
    .carry(carry), .neg(neg), .halted(halted)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] o;
    logic         c;
    int           at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out",     32'(out),   32'(e.o));
        chk("zero",    32'(zero),  32'(e.o == '0));
        chk("neg",     32'(neg),   32'(e.o[W-1]));
        chk("carry",   32'(carry), 32'(e.c));
        chk("latency", 32'(cyc),   32'(e.at));
      end
    end
  end

  // Present one start at the next edge, then scramble the operands to prove capture.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    OP = op; input_a = a; input_b = b; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; input_a = ~a; input_b = ~b;
  endtask

  // lat = extra edges after the start edge before done appears (0 for single-cycle ops).
  task automatic issue_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] o, input logic c, input int lat);
    exp_t e;
    e.o = o; e.c = c; e.at = cyc + 1 + lat;
    q.push_back(e);
    issue(op, a, b);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40 && busy; i++) begin
      @(posedge Clk); #1;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    repeat (n) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  initial begin
    start = 1'b0; OP = '0; input_a = '0; input_b = '0;

    // Reset state
    do_reset(2);
    chk("rst_out",    32'(out),    32'h00);
    chk("rst_zero",   32'(zero),   32'd1);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_carry",  32'(carry),  32'd0);
    chk("rst_neg",    32'(neg),    32'd0);

    // Back-to-back single-cycle ops
    issue_exp(3'b100, 8'hF0, 8'h20, 8'h10, 1'b1, 0);
    issue_exp(3'b101, 8'h7F, 8'h01, 8'h80, 1'b0, 0);
    issue_exp(3'b110, 8'h33, 8'h5A, 8'h5A, 1'b0, 0);
    issue_exp(3'b111, 8'h00, 8'hC3, 8'hC3, 1'b0, 0);
    issue_exp(3'b011, 8'h0F, 8'hF0, 8'h00, 1'b0, 0);
    issue_exp(3'b010, 8'h80, 8'h00, 8'h00, 1'b0, 0);
    issue_exp(3'b010, 8'h7F, 8'h00, 8'h01, 1'b0, 0);
    issue_exp(3'b011, 8'h01, 8'h02, 8'hFC, 1'b0, 0);
    // shf with amount 0 is single-cycle and clears carry
    issue_exp(3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 0);
    issue_exp(3'b001, 8'hA5, 8'h00, 8'hA5, 1'b0, 0);

    // Left shift by 3 with an ignored start during busy
    issue_exp(3'b001, 8'h03, 8'h03, 8'h18, 1'b0, 3);
    chk("busy_shift", 32'(busy), 32'd1);
    issue(3'b100, 8'h11, 8'h22);
    chk("busy_still", 32'(busy), 32'd1);
    wait_idle();

    // Right shift by 1, then by 8 (most-negative amount)
    issue_exp(3'b001, 8'h81, 8'h0F, 8'h40, 1'b1, 1);
    wait_idle();
    issue_exp(3'b001, 8'h81, 8'h08, 8'h00, 1'b1, 8);
    wait_idle();
    // Left shifts: by 1 (carry out of MSB), by 7 (last bit out is original bit 1)
    issue_exp(3'b001, 8'h81, 8'h01, 8'h02, 1'b1, 1);
    wait_idle();
    issue_exp(3'b001, 8'h81, 8'h07, 8'h80, 1'b0, 7);
    wait_idle();
    // Right by 3: bits out are 0,1,1 -> carry 1
    issue_exp(3'b001, 8'h76, 8'h0D, 8'h0E, 1'b1, 3);
    wait_idle();

    // stp halts; later starts are ignored
    issue_exp(3'b000, 8'h12, 8'h34, 8'h00, 1'b0, 0);
    chk("halted_set", 32'(halted), 32'd1);
    issue(3'b100, 8'h01, 8'h01);
    issue(3'b110, 8'h01, 8'h77);
    repeat (3) @(posedge Clk);
    #1;
    chk("halted_sticky", 32'(halted), 32'd1);
    chk("halted_out",    32'(out),    32'h00);

    // Reset mid-shift aborts without done
    do_reset(1);
    chk("rst2_halted", 32'(halted), 32'd0);
    issue(3'b001, 8'h01, 8'h05);
    chk("mid_busy", 32'(busy), 32'd1);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_done",   32'(done),   32'd0);
    chk("abort_halted", 32'(halted), 32'd0);
    chk("abort_out",    32'(out),    32'h00);
    repeat (8) @(posedge Clk);
    #1;

    // Operational after abort
    issue_exp(3'b100, 8'h05, 8'h06, 8'h0B, 1'b0, 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
